// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encoding for the universal shift register
//
// Purpose: operation-select constants used by univ_shift_register and its bench.
// Contents:
//   MODE_W     width of the mode select
//   MODE_*     operation encodings; 110 and 111 are unused and behave as HOLD
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - counts shifts and flags each completed word
//
// Purpose: counts shift/rotate operations modulo WIDTH and emits a one-cycle
//          word_done pulse on the cycle after the WIDTH-th shift.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   clock enable; 0 holds the count and drops word_done
//   inc        in   a shift or rotate is being applied this edge
//   clr        in   a parallel load is being applied this edge
//   bit_cnt    out  shifts since last load or word boundary (0..WIDTH-1)
//   word_done  out  one-cycle pulse after WIDTH shifts
module shift_bit_counter
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      // The pulse is only ever set by the wrapping increment below, so it
      // can never stretch across an idle or disabled cycle.
      r_done <= 1'b0;
      if (en) begin
        if (clr) begin
          r_cnt <= '0;
        end else if (inc) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      end
    end
  end

  assign bit_cnt   = r_cnt;
  assign word_done = r_done;

endmodule

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - parametrised universal shift register
//
// Purpose: WIDTH-bit register with hold, shift right/left, rotate right/left
//          and parallel load; usable as SIPO, PISO or SISO stage.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   en          in   clock enable; 0 = every register holds
//   mode        in   operation select (usr_pkg MODE_*)
//   serial_in   in   serial data in for SHR/SHL
//   par_in      in   parallel load data
//   q           out  register contents
//   serial_out  out  bit that leaves on the next shift in the current direction
//   bit_cnt     out  shifts since last load or word boundary
//   word_done   out  one-cycle pulse after each complete WIDTH-bit word
module univ_shift_register
  import usr_pkg::*;
#(
  parameter  int               WIDTH   = 8,
  parameter  logic [WIDTH-1:0] RST_VAL = '0,
  localparam int               CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              serial_in,
  input  logic [WIDTH-1:0]  par_in,
  output logic [WIDTH-1:0]  q,
  output logic              serial_out,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              word_done
);

  logic [WIDTH-1:0] r_q;
  logic             r_dir;   // 0 = right (LSB leaves), 1 = left (MSB leaves)

  logic [WIDTH-1:0] w_q_next;
  logic             w_dir_next;
  logic             w_shift;
  logic             w_load;

  always_comb begin
    w_q_next   = r_q;
    w_dir_next = r_dir;
    w_shift    = 1'b0;
    w_load     = 1'b0;
    case (mode)
      MODE_SHR: begin
        w_q_next   = {serial_in, r_q[WIDTH-1:1]};
        w_dir_next = 1'b0;
        w_shift    = 1'b1;
      end
      MODE_SHL: begin
        w_q_next   = {r_q[WIDTH-2:0], serial_in};
        w_dir_next = 1'b1;
        w_shift    = 1'b1;
      end
      MODE_ROR: begin
        w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
        w_dir_next = 1'b0;
        w_shift    = 1'b1;
      end
      MODE_ROL: begin
        w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_dir_next = 1'b1;
        w_shift    = 1'b1;
      end
      MODE_LOAD: begin
        w_q_next = par_in;
        w_load   = 1'b1;
      end
      default: ;  // HOLD and the unused encodings keep everything
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= RST_VAL;
      r_dir <= 1'b0;
    end else if (en) begin
      r_q   <= w_q_next;
      r_dir <= w_dir_next;
    end
  end

  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .inc       (w_shift),
    .clr       (w_load),
    .bit_cnt   (bit_cnt),
    .word_done (word_done)
  );

  assign q          = r_q;
  assign serial_out = r_dir ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - bench for univ_shift_register at WIDTH 4 and 8
module tb_univ_shift_register;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       serial_in;
  logic [7:0] par8;

  logic [3:0] q4;
  logic       so4;
  logic [2:0] cnt4;
  logic       wd4;
  logic [7:0] q8;
  logic       so8;
  logic [3:0] cnt8;
  logic       wd8;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] RV4 = 4'h9;
  localparam logic [7:0] RV8 = 8'h3C;

  univ_shift_register #(.WIDTH(4), .RST_VAL(RV4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in(serial_in),
    .par_in(par8[3:0]), .q(q4), .serial_out(so4), .bit_cnt(cnt4), .word_done(wd4)
  );

  univ_shift_register #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .serial_in(serial_in),
    .par_in(par8), .q(q8), .serial_out(so8), .bit_cnt(cnt8), .word_done(wd8)
  );

  always #5 clk = ~clk;

  // Reference model: register value as an integer, shift count as a plain
  // running tally of shifts since the last load/word boundary.
  int w_of[2] = '{4, 8};
  int m_q[2];
  int m_dir[2];
  int m_cnt[2];
  int m_done[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q[0] = int'(RV4);
    m_q[1] = int'(RV8);
    for (int k = 0; k < 2; k++) begin
      m_dir[k]  = 0;
      m_cnt[k]  = 0;
      m_done[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int w, top, sin, shifted;
      w       = w_of[k];
      top     = 1 << (w - 1);
      sin     = int'(serial_in);
      shifted = 0;
      m_done[k] = 0;
      if (en) begin
        case (mode)
          3'd1: begin m_q[k] = (m_q[k] / 2) + sin * top; m_dir[k] = 0; shifted = 1; end
          3'd2: begin m_q[k] = (m_q[k] * 2) % (2 * top) + sin; m_dir[k] = 1; shifted = 1; end
          3'd3: begin m_q[k] = (m_q[k] / 2) + (m_q[k] % 2) * top; m_dir[k] = 0; shifted = 1; end
          3'd4: begin m_q[k] = (m_q[k] * 2) % (2 * top) + m_q[k] / top; m_dir[k] = 1; shifted = 1; end
          3'd5: begin m_q[k] = int'(par8) % (2 * top); m_cnt[k] = 0; end
          default: ;
        endcase
        if (shifted != 0) begin
          m_cnt[k]++;
          if (m_cnt[k] == w) begin
            m_cnt[k]  = 0;
            m_done[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int so_exp4, so_exp8;
    so_exp4 = (m_dir[0] != 0) ? (m_q[0] / 8) % 2 : m_q[0] % 2;
    so_exp8 = (m_dir[1] != 0) ? (m_q[1] / 128) % 2 : m_q[1] % 2;
    chk({tag, ".q4"},   32'(q4),   32'(m_q[0]));
    chk({tag, ".so4"},  32'(so4),  32'(so_exp4));
    chk({tag, ".cnt4"}, 32'(cnt4), 32'(m_cnt[0]));
    chk({tag, ".wd4"},  32'(wd4),  32'(m_done[0]));
    chk({tag, ".q8"},   32'(q8),   32'(m_q[1]));
    chk({tag, ".so8"},  32'(so8),  32'(so_exp8));
    chk({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt[1]));
    chk({tag, ".wd8"},  32'(wd8),  32'(m_done[1]));
  endtask

  // Apply current inputs on the next rising edge, then compare after it.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic s, input logic [7:0] p);
    en = e; mode = m; serial_in = s; par8 = p;
  endtask

  // Reset pulse placed between clock edges; outputs must clear with no edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  logic [7:0] a5_bits;
  logic [3:0] shr_bits;

  initial begin
    rst = 1'b1;
    drive(1'b0, MODE_HOLD, 1'b0, 8'h00);
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Serial-in SHR, 4 bits, from a fresh count
    shr_bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, MODE_SHR, shr_bits[i], 8'h00);
      cycle("shr4");
      chk("shr4.wd_only_last", 32'(wd4), 32'(i == 3));
    end
    chk("shr4.q", 32'(q4), 32'h0000000D);
    chk("shr4.cnt", 32'(cnt4), 32'h0);

    // PISO: load A5, shift out 8 bits
    drive(1'b1, MODE_LOAD, 1'b0, 8'hA5);
    cycle("loadA5");
    a5_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("piso.so8", 32'(so8), 32'(a5_bits[i]));
      drive(1'b1, MODE_SHR, 1'b0, 8'h00);
      cycle("piso");
    end
    chk("piso.q8", 32'(q8), 32'h0);
    chk("piso.wd8", 32'(wd8), 32'h1);

    // ROL from 81, then a load mid-word
    drive(1'b1, MODE_LOAD, 1'b0, 8'h81);
    cycle("load81");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MODE_ROL, $urandom_range(0, 1), 8'h00);
      cycle("rol");
    end
    chk("rol.q8", 32'(q8), 32'h0C);
    chk("rol.so8", 32'(so8), 32'h0);
    chk("rol.cnt8", 32'(cnt8), 32'h3);
    drive(1'b1, MODE_LOAD, 1'b0, 8'h5A);
    cycle("midload");
    chk("midload.cnt8", 32'(cnt8), 32'h0);
    chk("midload.wd8", 32'(wd8), 32'h0);

    // SHL x2, disabled x3, SHL x2
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i < 5) drive(1'b0, MODE_SHL, 1'b1, 8'hFF);
      else                 drive(1'b1, MODE_SHL, 1'(i), 8'h00);
      cycle("shl_en");
    end
    chk("shl_en.wd4", 32'(wd4), 32'h1);

    // Unused encodings with enable high
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(6 + (i % 2)), 1'($urandom), 8'($urandom));
      cycle("unused");
    end

    // Reset mid-word, asynchronous to the clock
    drive(1'b1, MODE_SHR, 1'b1, 8'h00);
    cycle("pre_rst");
    async_reset("async_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom), 8'($urandom));
      cycle("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
